tx_packet_arbiter: RTL and testbench
====================================

// Module: tx_packet_arbiter
// PURPOSE
//  Shares the single serial TX packet encoder between N_REQ packet sources, e.g. a
//  telemetry producer and a command-response producer. Grants are round-robin.
//  The block sequences word_cnt one-cycle write_tx_word strobes into the encoder,
//  then holds the grant until the encoder has serialized the packet.
//  It sits between the user packet sources and the encoder write port inside the AVR/serial interface.
// PARAMETERS
//  N_REQ         2     number of requesters (1..8)
//  BUSY_TIMEOUT  1024  cycles to wait for tx_busy to rise after the last write
// PORTS
//  clk            in   1         system clock
//  rst            in   1         asynchronous, active-low reset
//  req            in   N_REQ     level; requester i has a complete packet ready
//  req_cnt        in   4*N_REQ   word count of requester i, bits [4i+3:4i]
//  req_type       in   4*N_REQ   response type of requester i, bits [4i+3:4i]
//  req_word       in   16*N_REQ  word selected by rd_idx, from requester i, bits [16i+15:16i]
//  grant          out  N_REQ     one-hot; owner of the encoder
//  rd_idx         out  4         index of the word the owner must drive on req_word
//  done           out  N_REQ     1-cycle pulse; packet of requester i finished
//  err            out  1         1-cycle pulse; zero-length packet or busy timeout
//  write_tx_word  out  1         1-cycle strobe to the encoder
//  tx_word        out  16        word for the encoder, valid with write_tx_word
//  tx_word_cnt    out  4         packet word count, held stable for the whole grant
//  tx_resp_type   out  4         packet response type, held stable for the whole grant
//  tx_busy        in   1         encoder busy serializing
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; rr pointer = 0; counters 0.
//  States: IDLE -> LOAD -> WRITE -> GAP -> (WRITE | WAIT_RISE) -> WAIT_FALL -> IDLE.
//  IDLE:
//   - If any req and tx_busy=0: pick the first asserted req at or above the rr pointer
//     (wrapping) and set that grant bit.
//   - Latch req_cnt/req_type of the winner into tx_word_cnt/tx_resp_type; rd_idx = 0.
//   - Go to LOAD.
//   - If tx_busy=1, stay in IDLE and grant nothing.
//  LOAD:
//   - If the latched cnt = 0: pulse err and done[i], drop grant, advance rr, go to IDLE.
//     No write is issued.
//   - Otherwise go to WRITE.
//  WRITE:
//   - Stall while tx_busy=1.
//   - Else sample req_word[owner] into tx_word and assert write_tx_word on the next cycle.
//     The strobe is registered; latency is rd_idx valid -> strobe = 1 cycle.
//  GAP:
//   - One idle cycle after each strobe; rd_idx increments.
//   - If rd_idx+1 < cnt go to WRITE, else go to WAIT_RISE.
//   - Strobes are therefore never on adjacent cycles.
//   - Exactly cnt strobes per packet; rd_idx runs 0..cnt-1 and never wraps.
//  WAIT_RISE:
//   - On tx_busy=1 go to WAIT_FALL.
//   - If BUSY_TIMEOUT cycles pass without the rise: pulse err, then finish as below.
//  WAIT_FALL:
//   - On tx_busy=0: pulse done[owner] and clear grant in the same cycle.
//   - Advance the rr pointer to owner+1 mod N_REQ and go to IDLE.
//   - This wait has no timeout.
//  The req level is sampled only in IDLE. Dropping req mid-packet is ignored; the packet completes.
//  A requester re-asserting in the done cycle is eligible on the next IDLE cycle, subject to rr.
//  tx_word_cnt and tx_resp_type change only in IDLE.
//  Reset mid-packet: outputs clear immediately; no partial strobe is emitted.
// TESTING
//  1. Single packet: req=01, cnt=3, type=5, words A,B,C.
//     -> 3 strobes, tx_word A,B,C, one gap cycle between each.
//     -> tx_busy pulses 20 cycles -> done=01 once.
//  2. Contention: req=11 held, cnt=1 each.
//     -> grants alternate 01,10,01,10 over 4 packets; grant is never 11.
//  3. Zero length: req=10, cnt=0 -> err and done=10 pulse.
//     -> no write_tx_word; the next grant goes to requester 0.
//  4. Encoder busy: tx_busy=1 in IDLE with req=01 -> no grant.
//     -> tx_busy falls -> grant on the next cycle.
//  5. Timeout: BUSY_TIMEOUT=16, tx_busy held 0 after the last strobe.
//     -> err after 16 cycles -> done pulse -> IDLE.
//  6. Async reset after strobe 2 of 4 -> outputs 0 at once.
//     -> after release, req=01 restarts the packet from rd_idx=0.

Source files
------------

// File: rtl/tx_packet_arbiter.sv
// Round-robin owner of the serial TX packet encoder: strobes each word of the granted
// packet into the encoder, then holds the grant until the encoder finishes serializing.
module tx_packet_arbiter #(
    parameter int N_REQ        = 2,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [4*N_REQ-1:0]    req_cnt,
    input  logic [4*N_REQ-1:0]    req_type,
    input  logic [16*N_REQ-1:0]   req_word,
    output logic [N_REQ-1:0]      grant,
    output logic [3:0]            rd_idx,
    output logic [N_REQ-1:0]      done,
    output logic                  err,
    output logic                  write_tx_word,
    output logic [15:0]           tx_word,
    output logic [3:0]            tx_word_cnt,
    output logic [3:0]            tx_resp_type,
    input  logic                  tx_busy
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, GAP, WAIT_RISE, WAIT_FALL
    } state_t;

    state_t            state_q;
    logic [OW-1:0]     rr_q;
    logic [OW-1:0]     owner_q;
    logic [TW-1:0]     timer_q;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  done_q;
    logic              err_q;
    logic              wr_q;
    logic [3:0]        rd_idx_q;
    logic [15:0]       tx_word_q;
    logic [3:0]        cnt_q;
    logic [3:0]        type_q;

    logic              win_vld_d;
    logic [OW-1:0]     win_d;

    function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] p);
        if (int'(p) == N_REQ - 1)
            return '0;
        return p + 1'b1;
    endfunction

    // Scan downward so the lowest offset from the rr pointer is written last and wins.
    always_comb begin
        win_vld_d = 1'b0;
        win_d     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_q) + k) % N_REQ]) begin
                win_vld_d = 1'b1;
                win_d     = OW'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            timer_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_idx_q  <= '0;
            tx_word_q <= '0;
            cnt_q     <= '0;
            type_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d && !tx_busy) begin
                        grant_q  <= N_REQ'(1) << win_d;
                        owner_q  <= win_d;
                        cnt_q    <= req_cnt[4*win_d +: 4];
                        type_q   <= req_type[4*win_d +: 4];
                        rd_idx_q <= '0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt_q == 4'd0) begin
                        err_q   <= 1'b1;
                        done_q  <= grant_q;
                        grant_q <= '0;
                        rr_q    <= next_ptr(owner_q);
                        state_q <= IDLE;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (!tx_busy) begin
                        tx_word_q <= req_word[16*owner_q +: 16];
                        wr_q      <= 1'b1;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (({1'b0, rd_idx_q} + 5'd1) < {1'b0, cnt_q}) begin
                        rd_idx_q <= rd_idx_q + 4'd1;
                        state_q  <= WRITE;
                    end else begin
                        timer_q <= '0;
                        state_q <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (tx_busy) begin
                        timer_q <= '0;
                        state_q <= WAIT_FALL;
                    end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                        // Encoder never started: flag it, then release through WAIT_FALL.
                        err_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= WAIT_FALL;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_FALL: begin
                    if (!tx_busy) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        rr_q    <= next_ptr(owner_q);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant         = grant_q;
    assign rd_idx        = rd_idx_q;
    assign done          = done_q;
    assign err           = err_q;
    assign write_tx_word = wr_q;
    assign tx_word       = tx_word_q;
    assign tx_word_cnt   = cnt_q;
    assign tx_resp_type  = type_q;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Bench for tx_packet_arbiter: two requesters, a simple encoder busy model and a
// scoreboard of expected words and grants.
module tb_tx_packet_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [7:0]  req_cnt = '0;
    logic [7:0]  req_type = '0;
    logic [31:0] req_word;
    logic [1:0]  grant;
    logic [3:0]  rd_idx;
    logic [1:0]  done;
    logic        err;
    logic        write_tx_word;
    logic [15:0] tx_word;
    logic [3:0]  tx_word_cnt;
    logic [3:0]  tx_resp_type;
    logic        tx_busy;
    logic        force_busy = 1'b0;
    logic        enc_busy;
    int          busy_len = 3;
    int          bcnt;
    int          wcnt;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic [15:0] src_words [2][16];
    logic [15:0] exp_words [$];
    logic [1:0]  exp_grants [$];

    tx_packet_arbiter #(.N_REQ(2), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst_n), .req(req), .req_cnt(req_cnt), .req_type(req_type),
        .req_word(req_word), .grant(grant), .rd_idx(rd_idx), .done(done), .err(err),
        .write_tx_word(write_tx_word), .tx_word(tx_word), .tx_word_cnt(tx_word_cnt),
        .tx_resp_type(tx_resp_type), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tx_busy = enc_busy | force_busy;
    always_comb req_word = {src_words[1][rd_idx], src_words[0][rd_idx]};

    // Encoder: after the last word of a packet, busy for busy_len cycles (0 = never).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_busy <= 1'b0;
            bcnt     <= 0;
            wcnt     <= 0;
        end else begin
            if (write_tx_word) begin
                if (wcnt + 1 >= int'(tx_word_cnt)) begin
                    wcnt <= 0;
                    if (busy_len > 0) begin
                        enc_busy <= 1'b1;
                        bcnt     <= busy_len;
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
            if (enc_busy) begin
                if (bcnt <= 1) enc_busy <= 1'b0;
                else bcnt <= bcnt - 1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        force_busy = 1'b0;
        busy_len = 3;
        exp_words.delete();
        exp_grants.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({grant, done, err, write_tx_word} !== 6'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000", {grant, done, err, write_tx_word});
        end
        tests++;
        if ({tx_word, tx_word_cnt, tx_resp_type, rd_idx} !== 28'd0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {tx_word, tx_word_cnt, tx_resp_type, rd_idx});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int nstb = 0, ndone = 0, last = 0, gapbad = 0;
        logic [15:0] w;
        do_reset();
        src_words[0][0] = 16'hA00A; src_words[0][1] = 16'hB00B; src_words[0][2] = 16'hC00C;
        req_cnt = 8'h03; req_type = 8'h05; busy_len = 20;
        exp_words.push_back(16'hA00A); exp_words.push_back(16'hB00B); exp_words.push_back(16'hC00C);
        req = 2'b01;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (grant == 2'b01) req = 2'b00;
            if (write_tx_word) begin
                if (nstb > 0 && cyc - last != 2) gapbad++;
                last = cyc;
                nstb++;
                w = (exp_words.size() > 0) ? exp_words.pop_front() : 16'hxxxx;
                tests++;
                if (tx_word !== w) begin
                    fails++;
                    $display("FAIL single_word%0d: got %h want %h", nstb, tx_word, w);
                end
                tests++;
                if ({tx_word_cnt, tx_resp_type} !== 8'h35) begin
                    fails++;
                    $display("FAIL single_cnt_type: got %h want 35", {tx_word_cnt, tx_resp_type});
                end
            end
            if (done !== 2'b00) begin
                ndone++;
                tests++;
                if (done !== 2'b01) begin
                    fails++;
                    $display("FAIL single_done: got %b want 01", done);
                end
            end
        end
        tests++;
        if (nstb != 3) begin fails++; $display("FAIL single_strobes: got %0d want 3", nstb); end
        tests++;
        if (gapbad != 0) begin fails++; $display("FAIL single_gap: got %0d bad gaps want 0", gapbad); end
        tests++;
        if (ndone != 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_contention();
        int ndone = 0, both = 0;
        logic [1:0] prevg = 2'b00, g;
        logic [15:0] w;
        do_reset();
        req_cnt = 8'h11;
        src_words[0][0] = 16'h1111; src_words[1][0] = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            exp_grants.push_back(2'b01); exp_words.push_back(16'h1111);
            exp_grants.push_back(2'b10); exp_words.push_back(16'h2222);
        end
        req = 2'b11;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (grant == 2'b11) both++;
            if (grant != 2'b00 && prevg == 2'b00) begin
                g = (exp_grants.size() > 0) ? exp_grants.pop_front() : 2'bxx;
                tests++;
                if (grant !== g) begin fails++; $display("FAIL contention_grant: got %b want %b", grant, g); end
            end
            if (write_tx_word) begin
                w = (exp_words.size() > 0) ? exp_words.pop_front() : 16'hxxxx;
                tests++;
                if (tx_word !== w) begin fails++; $display("FAIL contention_word: got %h want %h", tx_word, w); end
            end
            if (done !== 2'b00) begin
                ndone++;
                if (ndone == 4) req = 2'b00;
            end
            prevg = grant;
        end
        tests++;
        if (both != 0) begin fails++; $display("FAIL contention_grant11: got %0d cycles want 0", both); end
        tests++;
        if (ndone != 4 || exp_grants.size() != 0) begin
            fails++;
            $display("FAIL contention_count: got %0d dones, %0d grants left want 4, 0", ndone, exp_grants.size());
        end
    endtask

    task automatic test_zero_len();
        int nwr = 0, ndone = 0;
        logic seen = 1'b0;
        do_reset();
        req_cnt = 8'h01; req_type = 8'h00; src_words[0][0] = 16'h3333;
        req = 2'b10;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (write_tx_word) nwr++;
            if (err) begin
                seen = 1'b1;
                tests++;
                if (done !== 2'b10) begin fails++; $display("FAIL zero_done: got %b want 10", done); end
                req = 2'b11;
            end
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL zero_err: got no err pulse want one"); end
        tests++;
        if (nwr != 0) begin fails++; $display("FAIL zero_write: got %0d strobes want 0", nwr); end
        @(negedge clk);
        tests++;
        if (grant !== 2'b01) begin fails++; $display("FAIL zero_next_grant: got %b want 01", grant); end
        req = 2'b00;
        exp_words.push_back(16'h3333);
        for (int c = 0; c < 100 && ndone == 0; c++) begin
            @(negedge clk);
            if (write_tx_word) begin
                tests++;
                if (tx_word !== exp_words[0]) begin fails++; $display("FAIL zero_word: got %h want 3333", tx_word); end
                void'(exp_words.pop_front());
            end
            if (done !== 2'b00) begin
                ndone++;
                tests++;
                if (done !== 2'b01) begin fails++; $display("FAIL zero_done0: got %b want 01", done); end
            end
        end
        tests++;
        if (ndone != 1) begin fails++; $display("FAIL zero_done0_count: got %0d want 1", ndone); end
    endtask

    task automatic test_busy_idle();
        int ng = 0, ndone = 0;
        do_reset();
        force_busy = 1'b1;
        req_cnt = 8'h01; src_words[0][0] = 16'h4444;
        req = 2'b01;
        repeat (6) begin
            @(negedge clk);
            if (grant != 2'b00) ng++;
        end
        tests++;
        if (ng != 0) begin fails++; $display("FAIL busy_nogrant: got %0d granted cycles want 0", ng); end
        force_busy = 1'b0;
        @(negedge clk);
        tests++;
        if (grant !== 2'b01) begin fails++; $display("FAIL busy_grant_after_fall: got %b want 01", grant); end
        req = 2'b00;
        exp_words.push_back(16'h4444);
        for (int c = 0; c < 100 && ndone == 0; c++) begin
            @(negedge clk);
            if (write_tx_word) begin
                tests++;
                if (tx_word !== exp_words[0]) begin fails++; $display("FAIL busy_word: got %h want 4444", tx_word); end
                void'(exp_words.pop_front());
            end
            if (done !== 2'b00) ndone++;
        end
        tests++;
        if (ndone != 1) begin fails++; $display("FAIL busy_done: got %0d want 1", ndone); end
    endtask

    task automatic test_timeout();
        int nerr = 0, ndone = 0, tlast = 0, terr = 0, tdone = 0;
        do_reset();
        busy_len = 0;
        req_cnt = 8'h02; src_words[0][0] = 16'h5555; src_words[0][1] = 16'h6666;
        exp_words.push_back(16'h5555); exp_words.push_back(16'h6666);
        req = 2'b01;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (grant == 2'b01) req = 2'b00;
            if (write_tx_word) begin
                tlast = cyc;
                tests++;
                if (exp_words.size() == 0 || tx_word !== exp_words[0]) begin
                    fails++;
                    $display("FAIL timeout_word: got %h want next queued word", tx_word);
                end
                if (exp_words.size() > 0) void'(exp_words.pop_front());
            end
            if (err) begin nerr++; terr = cyc; end
            if (done !== 2'b00) begin
                ndone++;
                tdone = cyc;
                tests++;
                if (done !== 2'b01) begin fails++; $display("FAIL timeout_done: got %b want 01", done); end
            end
        end
        tests++;
        if (nerr != 1) begin fails++; $display("FAIL timeout_err_count: got %0d want 1", nerr); end
        tests++;
        if (terr - tlast < 16 || terr - tlast > 18) begin
            fails++;
            $display("FAIL timeout_delay: got %0d cycles want 16..18", terr - tlast);
        end
        tests++;
        if (ndone != 1 || tdone - terr != 1) begin
            fails++;
            $display("FAIL timeout_done_after_err: got %0d dones, %0d cycles want 1, 1", ndone, tdone - terr);
        end
        tests++;
        if (grant !== 2'b00) begin fails++; $display("FAIL timeout_idle: got grant %b want 00", grant); end
    endtask

    task automatic test_reset_mid();
        int nstb = 0, ndone = 0;
        logic checked_idx = 1'b0;
        do_reset();
        busy_len = 5;
        req_cnt = 8'h04;
        for (int i = 0; i < 4; i++) begin
            src_words[0][i] = 16'h7000 + 16'(i);
            exp_words.push_back(16'h7000 + 16'(i));
        end
        req = 2'b01;
        for (int c = 0; c < 100 && nstb < 2; c++) begin
            @(negedge clk);
            if (write_tx_word) begin
                nstb++;
                void'(exp_words.pop_front());
            end
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({grant, rd_idx, done, err, write_tx_word, tx_word, tx_word_cnt, tx_resp_type} !== 34'd0) begin
            fails++;
            $display("FAIL midreset_clear: got %h want 0",
                     {grant, rd_idx, done, err, write_tx_word, tx_word, tx_word_cnt, tx_resp_type});
        end
        exp_words.delete();
        for (int i = 0; i < 4; i++) exp_words.push_back(16'h7000 + 16'(i));
        nstb = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 200 && ndone == 0; c++) begin
            @(negedge clk);
            if (grant == 2'b01 && !checked_idx) begin
                checked_idx = 1'b1;
                req = 2'b00;
                tests++;
                if (rd_idx !== 4'd0) begin fails++; $display("FAIL midreset_rd_idx: got %0d want 0", rd_idx); end
            end
            if (write_tx_word) begin
                nstb++;
                tests++;
                if (exp_words.size() == 0 || tx_word !== exp_words[0]) begin
                    fails++;
                    $display("FAIL midreset_word%0d: got %h want %h", nstb, tx_word, 16'h7000 + 16'(nstb - 1));
                end
                if (exp_words.size() > 0) void'(exp_words.pop_front());
            end
            if (done !== 2'b00) ndone++;
        end
        tests++;
        if (nstb != 4 || ndone != 1) begin
            fails++;
            $display("FAIL midreset_restart: got %0d strobes, %0d dones want 4, 1", nstb, ndone);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++)
                src_words[i][j] = '0;
        test_reset();
        test_single();
        test_contention();
        test_zero_len();
        test_busy_idle();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
